// File: rtl/text_console_writer.sv
// Byte-stream to character-display bus writer: timed write cycles, cursor tracking, clear after reset.
// Optional CURSOR_TRACK_EN: mirror the cursor into the display registers after every accepted byte.
module text_console_writer #(
  parameter int         BUS_ASIZE     = 11,
  parameter int         BUS_DSIZE     = 8,
  parameter int         REG_BASE      = 'h7F0,
  parameter int         DISP_W        = 80,
  parameter int         DISP_H        = 25,
  parameter int         SETUP_CYCLES  = 2,
  parameter int         STROBE_CYCLES = 4,
  parameter int         HOLD_CYCLES   = 4,
  parameter logic [7:0] FILL_CHAR     = 8'h20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           char_in,
  input  logic                 char_valid,
  output logic                 char_ready,
  output logic [BUS_ASIZE-1:0] address,
  inout  wire  [BUS_DSIZE-1:0] data,
  output logic                 cs_n,
  output logic                 oe_n,
  output logic                 we_n,
  output logic                 busy
);

  localparam int TOTAL  = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES;
  localparam int CYW    = $clog2(TOTAL + 1);
  localparam int COLW   = $clog2(DISP_W);
  localparam int ROWW   = $clog2(DISP_H);
  localparam int NCELLS = DISP_W * DISP_H;

  localparam logic [CYW-1:0]       LAST_CYC = CYW'(TOTAL - 1);
  localparam logic [CYW-1:0]       STB_LO   = CYW'(SETUP_CYCLES);
  localparam logic [CYW-1:0]       STB_HI   = CYW'(SETUP_CYCLES + STROBE_CYCLES);
  localparam logic [COLW-1:0]      COL_LAST = COLW'(DISP_W - 1);
  localparam logic [BUS_ASIZE-1:0] CLR_LAST = BUS_ASIZE'(NCELLS - 1);
  localparam logic [BUS_ASIZE-1:0] A_CTRL   = BUS_ASIZE'(REG_BASE);
  localparam logic [BUS_ASIZE-1:0] A_COL    = BUS_ASIZE'(REG_BASE + 1);
  localparam logic [BUS_ASIZE-1:0] A_ROW    = BUS_ASIZE'(REG_BASE + 2);

  typedef enum logic [2:0] {CLEAR, IDLE, EXEC, WR_CHAR, WR_COL, WR_ROW, WR_CTRL} state_t;

`ifdef CURSOR_TRACK_EN
  localparam state_t               AFTER_CURSOR = WR_COL;
  localparam logic [BUS_DSIZE-1:0] CTRL_VAL     = BUS_DSIZE'(8'h40);
`else
  localparam state_t               AFTER_CURSOR = IDLE;
  localparam logic [BUS_DSIZE-1:0] CTRL_VAL     = BUS_DSIZE'(8'h00);
`endif

  state_t               state_q, state_d;
  logic [CYW-1:0]       cyc_q, cyc_d;
  logic [COLW-1:0]      col_q, col_d;
  logic [ROWW-1:0]      row_q, row_d;
  logic [BUS_ASIZE-1:0] clr_q, clr_d;
  logic [7:0]           char_q, char_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [BUS_ASIZE-1:0] addr_q, addr_d;
  logic [BUS_DSIZE-1:0] dout_q, dout_d;
  logic                 drive_q, drive_d;
  logic                 strobe_n_q, strobe_n_d;

  logic                 accept_s;
  logic                 wr_s;
  logic                 last_s;
  logic [BUS_ASIZE-1:0] text_addr_s;

  function automatic logic [ROWW-1:0] row_inc(input logic [ROWW-1:0] r);
    return (r == ROWW'(DISP_H - 1)) ? '0 : r + 1'b1;
  endfunction

  assign accept_s    = ready_q && char_valid;
  assign wr_s        = state_q inside {CLEAR, WR_CHAR, WR_COL, WR_ROW, WR_CTRL};
  assign last_s      = (cyc_q == LAST_CYC);
  assign text_addr_s = BUS_ASIZE'(row_q) * BUS_ASIZE'(DISP_W) + BUS_ASIZE'(col_q);

  // Next-state, cursor and handshake logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    clr_d   = clr_q;
    char_d  = char_q;
    if (wr_s && !last_s) begin
      cyc_d = cyc_q + 1'b1;
    end else begin
      cyc_d = '0;
    end
    case (state_q)
      CLEAR: begin
        if (last_s) begin
          if (clr_q == CLR_LAST) begin
            clr_d   = '0;
            state_d = WR_CTRL;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end else begin
          clr_d = clr_q;
        end
      end
      IDLE: begin
        if (accept_s) begin
          char_d  = char_in;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        case (char_q)
          8'h0D: begin
            col_d   = '0;
            state_d = AFTER_CURSOR;
          end
          8'h0A: begin
            row_d   = row_inc(row_q);
            state_d = AFTER_CURSOR;
          end
          8'h08: begin
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
            end else begin
              col_d = col_q;
            end
            state_d = AFTER_CURSOR;
          end
          8'h0C: begin
            col_d   = '0;
            row_d   = '0;
            clr_d   = '0;
            state_d = CLEAR;
          end
          default: state_d = WR_CHAR;
        endcase
      end
      WR_CHAR: begin
        // cursor advances only once the character has been committed to the bus
        if (last_s) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_inc(row_q);
          end else begin
            col_d = col_q + 1'b1;
          end
          state_d = AFTER_CURSOR;
        end else begin
          state_d = WR_CHAR;
        end
      end
      WR_CTRL: state_d = last_s ? WR_COL : WR_CTRL;
      WR_COL:  state_d = last_s ? WR_ROW : WR_COL;
      WR_ROW:  state_d = last_s ? IDLE : WR_ROW;
      default: begin
        state_d = CLEAR;
        clr_d   = '0;
      end
    endcase
    ready_d = (state_q == IDLE) && !accept_s;
    busy_d  = !ready_d;
  end

  // Bus drive values for the next clock, one cycle behind the write-state counter
  always_comb begin
    addr_d = addr_q;
    dout_d = dout_q;
    case (state_q)
      CLEAR: begin
        addr_d = clr_q;
        dout_d = BUS_DSIZE'(FILL_CHAR);
      end
      WR_CHAR: begin
        addr_d = text_addr_s;
        dout_d = BUS_DSIZE'(char_q);
      end
      WR_CTRL: begin
        addr_d = A_CTRL;
        dout_d = CTRL_VAL;
      end
      WR_COL: begin
        addr_d = A_COL;
        dout_d = BUS_DSIZE'(col_q);
      end
      WR_ROW: begin
        addr_d = A_ROW;
        dout_d = BUS_DSIZE'(row_q);
      end
      default: begin
        addr_d = addr_q;
        dout_d = dout_q;
      end
    endcase
    if (wr_s) begin
      drive_d    = 1'b1;
      strobe_n_d = !((cyc_q >= STB_LO) && (cyc_q < STB_HI));
    end else begin
      drive_d    = 1'b0;
      strobe_n_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR;
      cyc_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      clr_q      <= '0;
      char_q     <= 8'h00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      addr_q     <= '0;
      dout_q     <= '0;
      drive_q    <= 1'b0;
      strobe_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      col_q      <= col_d;
      row_q      <= row_d;
      clr_q      <= clr_d;
      char_q     <= char_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      drive_q    <= drive_d;
      strobe_n_q <= strobe_n_d;
    end
  end

  assign address    = addr_q;
  assign data       = drive_q ? dout_q : {BUS_DSIZE{1'bz}};
  assign cs_n       = strobe_n_q;
  assign we_n       = strobe_n_q;
  assign oe_n       = 1'b1;
  assign char_ready = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench: bus monitor rebuilds write transactions, a cursor/screen model predicts them.
module tb_text_console_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [10:0] address;
  wire  [7:0]  data;
  logic        cs_n, oe_n, we_n, busy;

  text_console_writer dut (
    .clock(clock), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .address(address), .data(data),
    .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n), .busy(busy)
  );

  always #5 clock = ~clock;

`ifdef CURSOR_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  int checks_n = 0;
  int errors_n = 0;
  int mon_viol = 0;
  int m_col = 0;
  int m_row = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic ref_write(input int a, input int d);
    exp_q.push_back({12'(a), 8'(d)});
  endtask

  task automatic ref_clear();
    for (int a = 0; a < 80 * 25; a++) ref_write(a, 'h20);
    ref_write('h7F0, TRACK ? 'h40 : 'h00);
    ref_write('h7F1, 0);
    ref_write('h7F2, 0);
    m_col = 0;
    m_row = 0;
  endtask

  task automatic ref_byte(input logic [7:0] b);
    case (b)
      8'h0D: m_col = 0;
      8'h0A: m_row = (m_row + 1) % 25;
      8'h08: if (m_col > 0) m_col = m_col - 1;
      8'h0C: begin
        ref_clear();
        return;
      end
      default: begin
        ref_write(m_row * 80 + m_col, b);
        m_col = m_col + 1;
        if (m_col == 80) begin
          m_col = 0;
          m_row = (m_row + 1) % 25;
        end
      end
    endcase
    if (TRACK) begin
      ref_write('h7F1, m_col);
      ref_write('h7F2, m_row);
    end
  endtask

  // ---------------- bus monitor ----------------
  initial begin
    logic        prev_cs;
    int          mode;
    int          stable_n, strobe_n, hold_n;
    logic [10:0] wa, last_a;
    logic [7:0]  wd, last_d;
    prev_cs = 1'b1; mode = 0; stable_n = 0; strobe_n = 0; hold_n = 0;
    wa = '0; wd = '0; last_a = '0; last_d = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mode = 0;
        prev_cs = 1'b1;
        stable_n = 0;
      end else begin
        if (we_n !== cs_n || oe_n !== 1'b1) mon_viol++;
        if (address == last_a && data == last_d) stable_n++;
        else stable_n = 1;
        if (!cs_n) begin
          if (prev_cs) begin
            if (stable_n < 3 || mode == 2) mon_viol++;
            wa = address; wd = data; strobe_n = 1; mode = 1;
          end else begin
            if (address != wa || data != wd) mon_viol++;
            strobe_n++;
          end
        end else if (mode == 1) begin
          if (strobe_n != 4) mon_viol++;
          if (address != wa || data != wd) mon_viol++;
          hold_n = 1; mode = 2;
        end else if (mode == 2) begin
          if (address != wa || data != wd) mon_viol++;
          hold_n++;
        end
        if (mode == 2 && hold_n == 4) begin
          got_q.push_back({12'(wa), wd});
          mode = 0;
        end
        prev_cs = cs_n; last_a = address; last_d = data;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input int budget);
    int n = 0;
    while (char_ready !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    char_valid = 1'b0;
    if (char_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready(25000);
    char_in = b;
    char_valid = 1'b1;
    @(negedge clock);
    check("ready_drop", char_ready, 1'b0);
    check("busy_on", busy, 1'b1);
    ref_byte(b);
    char_in = 8'($urandom);  // junk held valid while the block is busy
    wait_ready(25000);
  endtask

  task automatic compare_writes(input string tag);
    logic [19:0] g, e;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_wr"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
    check("bus_timing", mon_viol, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b;
    int n, r;
    repeat (3) @(posedge clock);
    #1;
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_we_n", we_n, 1'b1);
    check("rst_oe_n", oe_n, 1'b1);
    check("rst_addr", address, 11'h000);
    check("rst_ready", char_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    ref_clear();
    wait_ready(25000);
    compare_writes("clear");
    check("idle_busy", busy, 1'b0);

    send_byte(8'h41);
    compare_writes("char_A");

    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'h0D;
      else if (r < 4) b = 8'h0A;
      else if (r < 5) b = 8'h08;
      else b = 8'($urandom_range(0, 255));
      if (b == 8'h0C) b = 8'h2E;
      send_byte(b);
      compare_writes("rand");
    end

    send_byte(8'h0D);
    while (m_row != 24) send_byte(8'h0A);
    while (m_col != 79) send_byte(8'(8'h61 + m_col % 26));
    compare_writes("nav");
    send_byte(8'h5A);
    check("wrap_addr", (got_q.size() > 0) ? got_q[0][19:8] : 12'hFFF, 12'h7CF);
    compare_writes("wrap");
    send_byte(8'h2B);
    compare_writes("after_wrap");

    send_byte(8'h0D);
    while (m_row != 5) send_byte(8'h0A);
    compare_writes("nav5");
    send_byte(8'h08);
    compare_writes("bs_col0");
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h6B);
    check("row6_addr", (got_q.size() > 0) ? got_q[0][19:8] : 12'hFFF, 12'd480);
    compare_writes("row6");

    send_byte(8'h0C);
    compare_writes("ff_clear");
    send_byte(8'h48);
    send_byte(8'h49);
    compare_writes("hi");

    wait_ready(25000);
    char_in = 8'h52;
    char_valid = 1'b1;
    @(negedge clock);
    char_valid = 1'b0;
    n = 0;
    while (we_n !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("strobe_seen", we_n, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_we_n", we_n, 1'b1);
    check("midrst_busy", busy, 1'b1);
    repeat (2) @(negedge clock);
    check("midrst_partial", got_q.size(), 0);
    got_q.delete();
    exp_q.delete();
    reset = 1'b0;
    ref_clear();
    wait_ready(25000);
    compare_writes("rst_clear");
    send_byte(8'(8'h21 + $urandom_range(0, 90)));
    compare_writes("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Bus initiator that drives the asynchronous 8-bit character-display bus (cs_n/oe_n/we_n, 11-bit address) of the text frame buffer from a byte stream.
- Converts characters with a valid/ready handshake into timed write cycles to display RAM and to the cursor registers at REG_BASE+0..2.
- Tracks cursor column and row and handles control codes.
- Performs a clear-screen sequence after reset; sits between a UART/CPU byte source and the frame buffer's bus port.

Parameters:
- BUS_ASIZE, 11, bus address width
- BUS_DSIZE, 8, bus data width
- REG_BASE, 'h7F0, base address of the cursor registers (+0 ctrl, bit6 = cursor enable; +1 col; +2 row)
- DISP_W, 80, display width in characters
- DISP_H, 25, display height in characters
- SETUP_CYCLES, 2, clocks with address/data valid before the strobe (≥1)
- STROBE_CYCLES, 4, clocks with cs_n=we_n=0 (≥1)
- HOLD_CYCLES, 4, clocks address/data held after the strobe (≥4; the responder commits 3–4 clocks after strobe release)
- FILL_CHAR, 8'h20, character written by the clear operation

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- char_in  input  8  character/control byte
- char_valid  input  1  char_in valid
- char_ready  output  1  block can accept a byte this cycle
- address  output  BUS_ASIZE  bus address
- data  inout  BUS_DSIZE  bus data; driven only from SETUP through HOLD, else high-Z
- cs_n  output  1  chip select, active low
- oe_n  output  1  output enable; held at 1 (block never reads)
- we_n  output  1  write strobe, active low
- busy  output  1  high while a bus sequence or clear is in progress

Behaviour:
- Reset values:
  - cs_n=1, we_n=1, oe_n=1, data high-Z
  - address=0, char_ready=0, busy=1
  - cursor col=0, row=0
  - state=CLEAR
- Reset asserted mid-cycle:
  - cs_n/we_n go to 1 at the next edge and data is released.
  - The partially written location is not retried; CLEAR restarts from address 0.
- Bus write primitive, total SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES clocks:
  - SETUP: address/data driven, cs_n=we_n=1.
  - STROBE: cs_n=we_n=0.
  - HOLD: cs_n=we_n=1, address/data unchanged.
  - Address/data are stable during all three phases.
  - No gap is required between back-to-back writes.
- States: CLEAR, IDLE, EXEC, WR_CHAR, WR_COL, WR_ROW, WR_CTRL.
- CLEAR:
  - Writes FILL_CHAR to addresses 0 .. DISP_W*DISP_H-1 in ascending order.
  - Then goes to WR_CTRL, which writes {1'b0, 1'b1, 6'b0} to REG_BASE+0.
  - Then WR_COL and WR_ROW write 0, then IDLE.
- IDLE:
  - char_ready=1, busy=0.
  - On char_valid && char_ready the byte is latched and the FSM moves to EXEC.
  - char_ready=0 from the next cycle until the FSM returns to IDLE.
  - char_in is ignored while char_ready=0.
- EXEC, decode of the latched byte:
  - 8'h0D (CR): col←0.
  - 8'h0A (LF): row←row+1; row==DISP_H-1 wraps to 0.
  - 8'h08 (BS): if col>0 then col←col-1; at col 0 nothing changes.
  - 8'h0C (FF): cursor←(0,0), go to CLEAR.
  - Any other byte: WR_CHAR writes the byte to address row*DISP_W+col, then col←col+1. If col was DISP_W-1: col←0 and row advances with LF wrap.
- After a CR, LF, BS or printable byte: WR_COL writes the updated col to REG_BASE+1, WR_ROW writes row to REG_BASE+2, then IDLE. Exception: see the optional feature.
- Arithmetic and widths:
  - Display address is computed at the width of BUS_ASIZE.
  - DISP_W*DISP_H must be ≤ REG_BASE; the block never writes text at or above REG_BASE.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro CURSOR_TRACK_EN.
- Defined:
  - Behaviour as above: cursor register writes follow every accepted non-FF byte.
  - WR_CTRL writes bit6=1.
- Undefined:
  - WR_COL/WR_ROW are skipped after characters; only the post-CLEAR writes of 0 remain.
  - WR_CTRL writes 8'h00 (cursor disabled).
  - Per-character latency drops to one bus write.

Test Plan:
- Release reset → exactly 2000 writes of 8'h20 to 0x000..0x7CF, then 8'h40→0x7F0, 8'h00→0x7F1, 8'h00→0x7F2; char_ready rises afterward; each strobe is exactly 4 clocks with address stable 2 before and 4 after.
- Send 'A' (8'h41) at (0,0) → write 8'h41→0x000, 8'h01→0x7F1, 8'h00→0x7F2; char_ready low from the accept cycle+1 until all 3 writes complete.
- Cursor at col 79, row 24, send 8'h5A → 8'h5A→0x7CF, then col 0→0x7F1, row 0→0x7F2 (double wrap).
- At (0,5) send BS → no data write, col 0→0x7F1, row 5→0x7F2; then CR, LF → row 6 reported, col 0.
- Assert reset during the STROBE of a character write → cs_n=we_n=1 and data high-Z on the next edge; CLEAR restarts at 0x000.
- Build without CURSOR_TRACK_EN, send "HI" → only 0x000←8'h48 and 0x001←8'h49 after the CLEAR sequence; 0x7F0 received 8'h00.
